load_store_unit: RTL and testbench

Data-memory load/store unit fed by the execute stage: it consumes the ALU's 32-bit result as the effective address, alongside rs2 as store data. It performs one memory transaction per accepted operation over a req/ack handshake with wait states. It generates byte masks and replicated store data, and aligns and extends load data. Results go to register writeback; misaligned or illegal accesses are reported as faults without touching memory.

---
 rtl/load_store_unit_if.sv | 49 ++++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Bundles the execute-stage op handshake, the data-memory req/ack
//            bus and the register writeback signals of the load/store unit.
// Modports : slave  - the load/store unit itself
//            master - the surrounding pipeline / memory model
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  // execute-stage op
  logic        valid;
  logic        ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  // data memory
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  // retirement / writeback
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  modport slave (
    input  valid, is_load, is_store, funct3, addr, store_data, rd,
           dmem_ack, dmem_rdata,
    output ready, dmem_req, dmem_addr, dmem_wen, dmem_mask, dmem_wdata,
           done, wb_valid, wb_rd, wb_data, fault
  );

  modport master (
    output valid, is_load, is_store, funct3, addr, store_data, rd,
           dmem_ack, dmem_rdata,
    input  ready, dmem_req, dmem_addr, dmem_wen, dmem_mask, dmem_wdata,
           done, wb_valid, wb_rd, wb_data, fault
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory load/store unit. Takes the ALU result as effective
//            address and rs2 as store data, runs one req/ack memory
//            transaction per accepted op, builds byte masks / replicated
//            store data, aligns and extends load data, and reports
//            misaligned or illegal ops as faults without touching memory.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - load_store_unit_if.slave (op in, dmem bus, writeback)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]  r_state;
  logic        r_req;
  logic [31:0] r_dmem_addr;
  logic        r_wen;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_fault;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_fault;
  logic        w_mem_op;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  // Fault / mask / store-data decode of the op presented this cycle.
  always_comb begin
    w_bad_f3 = 1'b0;
    if (bus.is_load) begin
      case (bus.funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_bad_f3 = 1'b0;
        default:                                w_bad_f3 = 1'b1;
      endcase
    end else if (bus.is_store) begin
      w_bad_f3 = bus.funct3[2] | (bus.funct3[1:0] == 2'b11);
    end

    w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    w_mem_op   = bus.is_load | bus.is_store;
    w_fault    = (bus.is_load & bus.is_store) | (w_mem_op & (w_bad_f3 | w_misalign));

    w_mask  = 4'b1111;
    w_wdata = bus.store_data;
    if (!bus.is_load) begin
      case (bus.funct3[1:0])
        2'b00: begin
          w_mask  = 4'b0001 << bus.addr[1:0];
          w_wdata = {4{bus.store_data[7:0]}};
        end
        2'b01: begin
          w_mask  = bus.addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{bus.store_data[15:0]}};
        end
        default: begin
          w_mask  = 4'b1111;
          w_wdata = bus.store_data;
        end
      endcase
    end
  end

  // Load alignment uses the offset/size latched at acceptance.
  always_comb begin
    w_shifted = bus.dmem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_req       <= 1'b0;
      r_dmem_addr <= 32'd0;
      r_wen       <= 1'b0;
      r_mask      <= 4'd0;
      r_wdata     <= 32'd0;
      r_done      <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      r_fault     <= 1'b0;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
    end else begin
      // retirement outputs are single-cycle pulses
      r_done     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.valid) begin
            r_wb_rd   <= bus.rd;
            r_funct3  <= bus.funct3;
            r_off     <= bus.addr[1:0];
            r_is_load <= bus.is_load & ~bus.is_store;
            if (w_fault || !w_mem_op) begin
              // no memory access: retire straight from RESP
              r_state <= c_st_resp;
              r_done  <= 1'b1;
              r_fault <= w_fault;
            end else begin
              r_state     <= c_st_req;
              r_req       <= 1'b1;
              r_dmem_addr <= {bus.addr[31:2], 2'b00};
              r_wen       <= bus.is_store;
              r_mask      <= w_mask;
              r_wdata     <= w_wdata;
            end
          end
        end
        c_st_req: begin
          if (bus.dmem_ack) begin
            r_state    <= c_st_resp;
            r_req      <= 1'b0;
            r_done     <= 1'b1;
            r_wb_valid <= r_is_load;
            if (r_is_load) begin
              r_wb_data <= w_load_data;
            end
          end
        end
        c_st_resp: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.ready      = (r_state == c_st_idle);
  assign bus.dmem_req   = r_req;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wen   = r_wen;
  assign bus.dmem_mask  = r_mask;
  assign bus.dmem_wdata = r_wdata;
  assign bus.done       = r_done;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. Each op's expected
//            result is queued when it is driven and popped when the unit
//            retires it; a small memory responder inserts wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    int          waits;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    int          req_cnt;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          done_off;
    int          ready_off;
    logic        fault;
    logic        wbv;
    logic [31:0] wbd;
    logic [4:0]  wbrd;
  } exp_t;

  exp_t sb_q[$];
  exp_t obs;
  logic obs_stable;
  int   obs_acc;
  int   n_cmp = 0;
  int   n_err = 0;

  // Present one op and wait for the edge that accepts it.
  task automatic issue(input op_t op);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: ready=%b required 1", bus.ready);
    end
    bus.valid      = 1'b1;
    bus.is_load    = op.ld;
    bus.is_store   = op.st;
    bus.funct3     = op.f3;
    bus.addr       = op.addr;
    bus.store_data = op.sd;
    bus.rd         = op.rd;
    @(posedge clk);
    #1;
    obs_acc        = cyc;
    bus.valid      = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.addr       = 32'hFFFF_FFFF;
    bus.store_data = 32'h5555_AAAA;
  endtask

  // Issue an op, act as memory, and record what the unit did.
  task automatic run_op(input op_t op);
    int waited;
    issue(op);
    obs        = '{0, 1'b0, 32'd0, 4'd0, 32'd0, -1, -1, 1'b0, 1'b0, 32'd0, 5'd0};
    obs_stable = 1'b1;
    waited     = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.dmem_req) begin
        if (obs.req_cnt == 0) begin
          obs.wen   = bus.dmem_wen;
          obs.addr  = bus.dmem_addr;
          obs.mask  = bus.dmem_mask;
          obs.wdata = bus.dmem_wdata;
        end else if (bus.dmem_wen !== obs.wen || bus.dmem_addr !== obs.addr ||
                     bus.dmem_mask !== obs.mask || bus.dmem_wdata !== obs.wdata) begin
          obs_stable = 1'b0;
        end
        obs.req_cnt++;
      end
      if (bus.done && obs.done_off < 0) begin
        obs.done_off = c;
        obs.fault    = bus.fault;
        obs.wbv      = bus.wb_valid;
        obs.wbd      = bus.wb_data;
        obs.wbrd     = bus.wb_rd;
      end
      if (bus.ready && obs.done_off > 0 && obs.ready_off < 0) begin
        obs.ready_off = c;
        break;
      end
      if (bus.dmem_req) begin
        if (waited >= op.waits) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = op.rdata;
        end else begin
          waited++;
        end
      end
      @(posedge clk);
      #1;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h0BAD_0BAD;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.ready !== 1'b1)     begin n_err++; $display("FAIL rst_ready: got %b need 1", bus.ready); end
    n_cmp++; if (bus.dmem_req !== 1'b0)  begin n_err++; $display("FAIL rst_req: got %b need 0", bus.dmem_req); end
    n_cmp++; if (bus.done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %b need 0", bus.done); end
    n_cmp++; if (bus.dmem_mask !== 4'd0) begin n_err++; $display("FAIL rst_mask: got %h need 0", bus.dmem_mask); end
    n_cmp++; if (bus.wb_data !== 32'd0)  begin n_err++; $display("FAIL rst_wbdata: got %h need 0", bus.wb_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stores;
    op_t  ops[3];
    exp_t e;
    ops[0] = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9, 0, 32'd0};
    ops[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd9, 1, 32'd0};
    ops[2] = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 5'd9, 0, 32'd0};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: sb_q.push_back('{1, 1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 2, 3, 1'b0, 1'b0, 32'd0, 5'd0});
        1: sb_q.push_back('{2, 1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD, 3, 4, 1'b0, 1'b0, 32'd0, 5'd0});
        default: sb_q.push_back('{1, 1'b1, 32'h100, 4'b0010, 32'hA5A5_A5A5, 2, 3, 1'b0, 1'b0, 32'd0, 5'd0});
      endcase
      run_op(ops[i]);
      e = sb_q.pop_front();
      n_cmp++; if (obs.req_cnt !== e.req_cnt) begin n_err++; $display("FAIL st%0d_req_cycles: got %0d need %0d", i, obs.req_cnt, e.req_cnt); end
      n_cmp++; if (obs.wen !== e.wen)         begin n_err++; $display("FAIL st%0d_wen: got %b need %b", i, obs.wen, e.wen); end
      n_cmp++; if (obs.addr !== e.addr)       begin n_err++; $display("FAIL st%0d_addr: got %h need %h", i, obs.addr, e.addr); end
      n_cmp++; if (obs.mask !== e.mask)       begin n_err++; $display("FAIL st%0d_mask: got %b need %b", i, obs.mask, e.mask); end
      n_cmp++; if (obs.wdata !== e.wdata)     begin n_err++; $display("FAIL st%0d_wdata: got %h need %h", i, obs.wdata, e.wdata); end
      n_cmp++; if (obs.done_off !== e.done_off) begin n_err++; $display("FAIL st%0d_done_cycle: got %0d need %0d", i, obs.done_off, e.done_off); end
      n_cmp++; if (obs.wbv !== e.wbv || obs.fault !== e.fault) begin n_err++; $display("FAIL st%0d_wbv_fault: got %b%b need %b%b", i, obs.wbv, obs.fault, e.wbv, e.fault); end
    end
  endtask

  task automatic test_loads;
    op_t  ops[5];
    exp_t e;
    ops[0] = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 5'd7,  3, 32'h80FF_1234};
    ops[1] = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 5'd12, 0, 32'h8001_0000};
    ops[2] = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'd0, 5'd3,  2, 32'h0000_8001};
    ops[3] = '{1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'd0, 5'd31, 0, 32'h0000_9A00};
    ops[4] = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'd0, 5'd1,  1, 32'hCAFE_F00D};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: sb_q.push_back('{4, 1'b0, 32'h200, 4'b1111, 32'd0, 5, 6, 1'b0, 1'b1, 32'hFFFF_FF80, 5'd7});
        1: sb_q.push_back('{1, 1'b0, 32'h100, 4'b1111, 32'd0, 2, 3, 1'b0, 1'b1, 32'h0000_8001, 5'd12});
        2: sb_q.push_back('{3, 1'b0, 32'h100, 4'b1111, 32'd0, 4, 5, 1'b0, 1'b1, 32'hFFFF_8001, 5'd3});
        3: sb_q.push_back('{1, 1'b0, 32'h200, 4'b1111, 32'd0, 2, 3, 1'b0, 1'b1, 32'h0000_009A, 5'd31});
        default: sb_q.push_back('{2, 1'b0, 32'h104, 4'b1111, 32'd0, 3, 4, 1'b0, 1'b1, 32'hCAFE_F00D, 5'd1});
      endcase
      run_op(ops[i]);
      e = sb_q.pop_front();
      n_cmp++; if (obs.req_cnt !== e.req_cnt) begin n_err++; $display("FAIL ld%0d_req_cycles: got %0d need %0d", i, obs.req_cnt, e.req_cnt); end
      n_cmp++; if (obs_stable !== 1'b1)       begin n_err++; $display("FAIL ld%0d_req_stable: got %b need 1", i, obs_stable); end
      n_cmp++; if (obs.addr !== e.addr || obs.wen !== e.wen || obs.mask !== e.mask) begin n_err++; $display("FAIL ld%0d_req_fields: got %h/%b/%b need %h/%b/%b", i, obs.addr, obs.wen, obs.mask, e.addr, e.wen, e.mask); end
      n_cmp++; if (obs.done_off !== e.done_off) begin n_err++; $display("FAIL ld%0d_done_cycle: got %0d need %0d", i, obs.done_off, e.done_off); end
      n_cmp++; if (obs.ready_off !== e.ready_off) begin n_err++; $display("FAIL ld%0d_ready_cycle: got %0d need %0d", i, obs.ready_off, e.ready_off); end
      n_cmp++; if (obs.wbv !== e.wbv)   begin n_err++; $display("FAIL ld%0d_wb_valid: got %b need %b", i, obs.wbv, e.wbv); end
      n_cmp++; if (obs.wbd !== e.wbd)   begin n_err++; $display("FAIL ld%0d_wb_data: got %h need %h", i, obs.wbd, e.wbd); end
      n_cmp++; if (obs.wbrd !== e.wbrd) begin n_err++; $display("FAIL ld%0d_wb_rd: got %0d need %0d", i, obs.wbrd, e.wbrd); end
    end
  endtask

  task automatic test_faults;
    op_t  ops[6];
    exp_t e;
    ops[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 5'd4, 0, 32'd0}; // LW misaligned
    ops[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'd0, 5'd4, 0, 32'd0}; // SH misaligned
    ops[2] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0, 5'd4, 0, 32'd0}; // load funct3 011
    ops[3] = '{1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'd0, 5'd4, 0, 32'd0}; // load and store
    ops[4] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'd0, 5'd4, 0, 32'd0}; // store funct3 100
    ops[5] = '{1'b0, 1'b0, 3'b010, 32'h0000_0001, 32'd0, 5'd4, 0, 32'd0}; // no-op
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{0, 1'b0, 32'd0, 4'd0, 32'd0, 1, 2, (i != 5), 1'b0, 32'd0, 5'd0});
      run_op(ops[i]);
      e = sb_q.pop_front();
      n_cmp++; if (obs.req_cnt !== e.req_cnt)     begin n_err++; $display("FAIL flt%0d_req_cycles: got %0d need %0d", i, obs.req_cnt, e.req_cnt); end
      n_cmp++; if (obs.done_off !== e.done_off)   begin n_err++; $display("FAIL flt%0d_done_cycle: got %0d need %0d", i, obs.done_off, e.done_off); end
      n_cmp++; if (obs.ready_off !== e.ready_off) begin n_err++; $display("FAIL flt%0d_ready_cycle: got %0d need %0d", i, obs.ready_off, e.ready_off); end
      n_cmp++; if (obs.fault !== e.fault)         begin n_err++; $display("FAIL flt%0d_fault: got %b need %b", i, obs.fault, e.fault); end
      n_cmp++; if (obs.wbv !== e.wbv)             begin n_err++; $display("FAIL flt%0d_wb_valid: got %b need %b", i, obs.wbv, e.wbv); end
    end
  endtask

  task automatic test_back_to_back;
    op_t op;
    int  t_first;
    op = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0102_0304, 5'd0, 0, 32'd0};
    run_op(op);
    t_first = obs_acc;
    op = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd20, 0, 32'h0102_0304};
    run_op(op);
    n_cmp++; if (obs_acc - t_first !== 3) begin n_err++; $display("FAIL b2b_interval: got %0d need 3", obs_acc - t_first); end
    n_cmp++; if (obs.wbd !== 32'h0102_0304) begin n_err++; $display("FAIL b2b_wb_data: got %h need 01020304", obs.wbd); end
  endtask

  task automatic test_reset_during_req;
    op_t op;
    op = '{1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd5, 0, 32'd0};
    issue(op);
    @(posedge clk);
    #1;
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_err++; $display("FAIL rreq_pending: got %b need 1", bus.dmem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL rreq_req_drop: got %b need 0", bus.dmem_req); end
    n_cmp++; if (bus.ready !== 1'b1)    begin n_err++; $display("FAIL rreq_ready: got %b need 1", bus.ready); end
    n_cmp++; if ({bus.dmem_wen, bus.done, bus.wb_valid, bus.fault} !== 4'b0) begin n_err++; $display("FAIL rreq_flags: got %b need 0000", {bus.dmem_wen, bus.done, bus.wb_valid, bus.fault}); end
    n_cmp++; if ({bus.dmem_addr, bus.dmem_mask, bus.dmem_wdata, bus.wb_rd, bus.wb_data} !== '0) begin n_err++; $display("FAIL rreq_data: got %h/%h/%h/%h/%h need all 0", bus.dmem_addr, bus.dmem_mask, bus.dmem_wdata, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
    rst_n = 1'b1;
    op = '{1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'd0, 5'd6, 0, 32'h1122_3344};
    sb_q.push_back('{1, 1'b0, 32'h408, 4'b1111, 32'd0, 2, 3, 1'b0, 1'b1, 32'h1122_3344, 5'd6});
    run_op(op);
    begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++; if (obs.req_cnt !== e.req_cnt)   begin n_err++; $display("FAIL post_rst_req_cycles: got %0d need %0d", obs.req_cnt, e.req_cnt); end
      n_cmp++; if (obs.done_off !== e.done_off) begin n_err++; $display("FAIL post_rst_done_cycle: got %0d need %0d", obs.done_off, e.done_off); end
      n_cmp++; if (obs.wbd !== e.wbd)           begin n_err++; $display("FAIL post_rst_wb_data: got %h need %h", obs.wbd, e.wbd); end
      n_cmp++; if (obs.wbrd !== e.wbrd)         begin n_err++; $display("FAIL post_rst_wb_rd: got %0d need %0d", obs.wbrd, e.wbrd); end
    end
  endtask

  initial begin
    bus.valid      = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'd0;
    bus.addr       = 32'd0;
    bus.store_data = 32'd0;
    bus.rd         = 5'd0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_back_to_back();
    test_reset_during_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
